// File: rtl/alu_flag_exec.sv
// rtl/alu_flag_exec.sv - execute-stage ALU with registered C/Z/N flags and iterative MUL
// Single-cycle ops commit on the accepting edge; MUL runs one shift-add step per cycle.
module alu_flag_exec #(
  parameter int N       = 16,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [3:0]         op,
  input  logic [N-1:0]       src_a,
  input  logic [N-1:0]       src_b,
  input  logic [N-1:0]       imm,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               in_port_sel,
  input  logic [N-1:0]       in_port,
  input  logic               flush,
  input  logic               flag_load,
  input  logic [2:0]         flag_in,
  output logic [N-1:0]       result,
  output logic               result_valid,
  output logic               carry_flag,
  output logic               zero_flag,
  output logic               neg_flag,
  output logic               busy
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       result_q, result_d;
  logic               result_valid_q, result_valid_d;
  logic               c_q, c_d, z_q, z_d, n_q, n_d;
  logic [2*N-1:0]     acc_q, acc_d, mcand_q, mcand_d;
  logic [N-1:0]       mplr_q, mplr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               accept;
  logic [N:0]         wide, shl_w, shr_w;
  logic [N-1:0]       alu_res;
  logic               alu_has, alu_zn, alu_cu, alu_c;
  logic [2*N-1:0]     prod;

  assign ready_out = (state_q == S_IDLE);
  assign accept    = valid_in && ready_out && !flush;

  // Shifting at N+1 bits leaves the last bit shifted out in the extra position.
  assign shl_w = {1'b0, src_a} << shamt;
  assign shr_w = {src_a, 1'b0} >> shamt;
  assign prod  = acc_q + (mplr_q[0] ? mcand_q : {(2*N){1'b0}});

  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_has = 1'b0;
    alu_zn  = 1'b0;
    alu_cu  = 1'b0;
    alu_c   = 1'b0;
    case (op)
      4'd0: begin
        alu_res = in_port;
        alu_has = in_port_sel;
      end
      4'd1: begin
        alu_res = ~src_a;
        alu_has = 1'b1; alu_zn = 1'b1; alu_cu = 1'b1;
      end
      4'd2, 4'd3, 4'd5, 4'd6: begin
        case (op)
          4'd2:    wide = {1'b0, src_a} + {{N{1'b0}}, 1'b1};
          4'd3:    wide = {1'b0, src_a} - {{N{1'b0}}, 1'b1};
          4'd5:    wide = {1'b0, src_a} + {1'b0, src_b};
          default: wide = {1'b0, src_a} - {1'b0, src_b};
        endcase
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_has = 1'b1; alu_zn = 1'b1; alu_cu = 1'b1;
      end
      4'd4, 4'd13: begin
        alu_res = src_a;
        alu_has = 1'b1;
      end
      4'd7: begin
        alu_res = src_a & src_b;
        alu_has = 1'b1; alu_zn = 1'b1;
      end
      4'd8: begin
        alu_res = src_a | src_b;
        alu_has = 1'b1; alu_zn = 1'b1;
      end
      4'd9: begin
        alu_res = shl_w[N-1:0];
        alu_c   = shl_w[N];
        alu_has = 1'b1; alu_zn = 1'b1; alu_cu = (shamt != '0);
      end
      4'd10: begin
        alu_res = shr_w[N:1];
        alu_c   = shr_w[0];
        alu_has = 1'b1; alu_zn = 1'b1; alu_cu = (shamt != '0);
      end
      4'd11: begin
        alu_cu = 1'b1; alu_c = 1'b1;
      end
      4'd12: alu_cu = 1'b1;
      4'd14: begin
        alu_res = imm;
        alu_has = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    result_d       = result_q;
    result_valid_d = 1'b0;
    c_d            = c_q;
    z_d            = z_q;
    n_d            = n_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplr_d         = mplr_q;
    cnt_d          = cnt_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept && op == 4'd15) begin
            state_d = S_MUL;
            acc_d   = '0;
            mcand_d = {{N{1'b0}}, src_a};
            mplr_d  = src_b;
            cnt_d   = '0;
          end else if (accept) begin
            if (alu_has) begin
              result_d       = alu_res;
              result_valid_d = 1'b1;
            end
            if (alu_zn) begin
              z_d = (alu_res == '0);
              n_d = alu_res[N-1];
            end
            if (alu_cu) c_d = alu_c;
          end
        end
        S_MUL: begin
          acc_d   = prod;
          mcand_d = mcand_q << 1;
          mplr_d  = mplr_q >> 1;
          cnt_d   = cnt_q + 1'b1;
          // The final step commits the product so it is visible during DONE.
          if (cnt_q == CNT_W'(N - 1)) begin
            state_d        = S_DONE;
            result_d       = prod[N-1:0];
            result_valid_d = 1'b1;
            z_d            = (prod[N-1:0] == '0);
            n_d            = prod[N-1];
            c_d            = (prod[2*N-1:N] != '0);
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (flag_load) {c_d, z_d, n_d} = flag_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      c_q            <= 1'b0;
      z_q            <= 1'b0;
      n_q            <= 1'b0;
      acc_q          <= '0;
      mcand_q        <= '0;
      mplr_q         <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      c_q            <= c_d;
      z_q            <= z_d;
      n_q            <= n_d;
      acc_q          <= acc_d;
      mcand_q        <= mcand_d;
      mplr_q         <= mplr_d;
      cnt_q          <= cnt_d;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign carry_flag   = c_q;
  assign zero_flag    = z_q;
  assign neg_flag     = n_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_flag_exec.sv
// tb/tb_alu_flag_exec.sv - self-checking bench for alu_flag_exec against an arithmetic reference model
module tb_alu_flag_exec;

  logic        clk = 1'b0;
  logic        rst, valid_in, ready_out, in_port_sel, flush, flag_load;
  logic [3:0]  op;
  logic [15:0] src_a, src_b, imm, in_port, result;
  logic [4:0]  shamt;
  logic [2:0]  flag_in;
  logic        result_valid, carry_flag, zero_flag, neg_flag, busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic c_m, z_m, n_m;

  always #5 clk = ~clk;

  alu_flag_exec #(.N(16), .SHAMT_W(5)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out), .op(op),
    .src_a(src_a), .src_b(src_b), .imm(imm), .shamt(shamt), .in_port_sel(in_port_sel),
    .in_port(in_port), .flush(flush), .flag_load(flag_load), .flag_in(flag_in),
    .result(result), .result_valid(result_valid), .carry_flag(carry_flag),
    .zero_flag(zero_flag), .neg_flag(neg_flag), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic [4:0] s);
    op = o; src_a = a; src_b = b; shamt = s; valid_in = 1'b1;
    step();
    valid_in = 1'b0; flag_load = 1'b0;
  endtask

  // Reference: plain integer arithmetic over the op table; updates model flags.
  function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] im, input int s, input logic sel, input logic [15:0] inp,
                                output logic has, output logic [15:0] r);
    longint la = a;
    longint lb = b;
    longint t;
    bit zn = 1'b1;
    has = 1'b1;
    r = 16'h0;
    case (o)
      0: begin r = inp; has = sel; zn = 1'b0; end
      1: begin r = ~a; c_m = 1'b0; end
      2: begin t = la + 1;  r = t[15:0]; c_m = (la == 65535); end
      3: begin t = la - 1;  r = t[15:0]; c_m = (la == 0); end
      5: begin t = la + lb; r = t[15:0]; c_m = (t > 65535); end
      6: begin t = la - lb; r = t[15:0]; c_m = (la < lb); end
      7: r = a & b;
      8: r = a | b;
      9: begin
        if (s == 0) r = a;
        else if (s <= 16) begin t = (la << s) & 65535; r = t[15:0]; c_m = a[16 - s]; end
        else begin r = 0; c_m = 1'b0; end
      end
      10: begin
        if (s == 0) r = a;
        else if (s <= 16) begin r = a >> s; c_m = a[s - 1]; end
        else begin r = 0; c_m = 1'b0; end
      end
      11: begin has = 1'b0; zn = 1'b0; c_m = 1'b1; end
      12: begin has = 1'b0; zn = 1'b0; c_m = 1'b0; end
      14: begin r = im; zn = 1'b0; end
      default: begin r = a; zn = 1'b0; end
    endcase
    if (zn) begin z_m = (r == 0); n_m = r[15]; end
  endfunction

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b1; op = 4'd5; src_a = 16'h1234; src_b = 16'h1111;
    step(); step();
    rst = 1'b0; valid_in = 1'b0;
    tests_run++;
    if ({result, result_valid, carry_flag, zero_flag, neg_flag, busy} !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got res=%h v=%b c=%b z=%b n=%b busy=%b exp all 0",
               result, result_valid, carry_flag, zero_flag, neg_flag, busy);
    end
    tests_run++;
    if (ready_out !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b exp 1", ready_out); end
    {c_m, z_m, n_m} = 3'b000;
  endtask

  task automatic test_directed();
    do_op(4'd5, 16'hFFFF, 16'h0001, 5'd0);
    tests_run++;
    if ({result_valid, result, carry_flag, zero_flag, neg_flag} !== {1'b1, 16'h0000, 3'b110}) begin
      tests_failed++;
      $display("FAIL add_wrap: got v=%b r=%h czn=%b%b%b exp v=1 r=0000 czn=110",
               result_valid, result, carry_flag, zero_flag, neg_flag);
    end
    step();
    tests_run++;
    if (result_valid !== 1'b0) begin tests_failed++; $display("FAIL valid_pulse: got %b exp 0", result_valid); end
    do_op(4'd6, 16'd3, 16'd5, 5'd0);
    tests_run++;
    if ({result, carry_flag, zero_flag, neg_flag} !== {16'hFFFE, 3'b101}) begin
      tests_failed++;
      $display("FAIL sub_borrow: got r=%h czn=%b%b%b exp FFFE 101", result, carry_flag, zero_flag, neg_flag);
    end
    do_op(4'd7, 16'h00F0, 16'h0F00, 5'd0);
    tests_run++;
    if ({result, carry_flag, zero_flag, neg_flag} !== {16'h0000, 3'b110}) begin
      tests_failed++;
      $display("FAIL and_keep_c: got r=%h czn=%b%b%b exp 0000 110", result, carry_flag, zero_flag, neg_flag);
    end
    do_op(4'd12, 16'h0, 16'h0, 5'd0);
    do_op(4'd9, 16'h8001, 16'h0, 5'd1);
    tests_run++;
    if ({result, carry_flag} !== {16'h0002, 1'b1}) begin
      tests_failed++;
      $display("FAIL shl_1: got r=%h c=%b exp 0002 1", result, carry_flag);
    end
    do_op(4'd10, 16'h8001, 16'h0, 5'd0);
    tests_run++;
    if ({result, carry_flag, neg_flag} !== {16'h8001, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL shr_0: got r=%h c=%b n=%b exp 8001 1 1", result, carry_flag, neg_flag);
    end
    do_op(4'd9, 16'hFFFF, 16'h0, 5'd20);
    tests_run++;
    if ({result, carry_flag, zero_flag} !== {16'h0000, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("FAIL shl_20: got r=%h c=%b z=%b exp 0000 0 1", result, carry_flag, zero_flag);
    end
    {c_m, z_m, n_m} = 3'b010;
  endtask

  task automatic test_flag_load();
    flag_in = 3'b101; flag_load = 1'b1;
    do_op(4'd5, 16'd1, 16'd1, 5'd0);
    tests_run++;
    if ({result_valid, result, carry_flag, zero_flag, neg_flag} !== {1'b1, 16'd2, 3'b101}) begin
      tests_failed++;
      $display("FAIL flag_load_add: got v=%b r=%h czn=%b%b%b exp 1 0002 101",
               result_valid, result, carry_flag, zero_flag, neg_flag);
    end
    do_op(4'd11, 16'h0, 16'h0, 5'd0);
    tests_run++;
    if ({result_valid, carry_flag} !== 2'b01) begin
      tests_failed++;
      $display("FAIL setc: got v=%b c=%b exp 0 1", result_valid, carry_flag);
    end
    do_op(4'd12, 16'h0, 16'h0, 5'd0);
    tests_run++;
    if ({result_valid, carry_flag} !== 2'b00) begin
      tests_failed++;
      $display("FAIL clrc: got v=%b c=%b exp 0 0", result_valid, carry_flag);
    end
    {c_m, z_m, n_m} = 3'b001;
  endtask

  task automatic test_random_single();
    logic        has, v, fl;
    logic [15:0] r, prev;
    logic [3:0]  o;
    for (int i = 0; i < 300; i++) begin
      o = 4'($urandom_range(0, 14));
      v = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 7) == 0);
      op = o; valid_in = v; flag_load = fl; flag_in = 3'($urandom);
      src_a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      src_b = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      imm = 16'($urandom); in_port = 16'($urandom); in_port_sel = 1'($urandom);
      shamt = 5'($urandom);
      prev = result;
      step();
      has = 1'b0; r = prev;
      if (v) model(o, src_a, src_b, imm, int'(shamt), in_port_sel, in_port, has, r);
      if (!has) r = prev;
      if (fl) {c_m, z_m, n_m} = flag_in;
      tests_run++;
      if (result_valid !== has || result !== r) begin
        tests_failed++;
        $display("FAIL rand_res op=%0d: got v=%b r=%h exp v=%b r=%h", o, result_valid, result, has, r);
      end
      tests_run++;
      if ({carry_flag, zero_flag, neg_flag} !== {c_m, z_m, n_m}) begin
        tests_failed++;
        $display("FAIL rand_flags op=%0d: got %b%b%b exp %b%b%b", o, carry_flag, zero_flag, neg_flag, c_m, z_m, n_m);
      end
    end
    valid_in = 1'b0; flag_load = 1'b0;
  endtask

  task automatic test_mul();
    logic [15:0] a, b;
    longint p;
    int cyc;
    int bad_ready;
    for (int i = 0; i < 6; i++) begin
      a = (i == 0) ? 16'd300 : (i == 1) ? 16'd7 : 16'($urandom);
      b = (i == 0) ? 16'd300 : (i == 1) ? 16'd6 : 16'($urandom);
      p = longint'(a) * longint'(b);
      do_op(4'd15, a, b, 5'd0);
      cyc = 1; bad_ready = 0;
      while (!result_valid && cyc < 40) begin
        if (ready_out !== 1'b0 || busy !== 1'b1) bad_ready++;
        step();
        cyc++;
      end
      if (ready_out !== 1'b0) bad_ready++;
      tests_run++;
      if (cyc != 17) begin tests_failed++; $display("FAIL mul_latency: got %0d cycles exp 17", cyc); end
      tests_run++;
      if (bad_ready != 0) begin tests_failed++; $display("FAIL mul_ready_low: got %0d bad cycles exp 0", bad_ready); end
      c_m = ((p >> 16) != 0); z_m = ((p & 65535) == 0); n_m = p[15];
      tests_run++;
      if ({result, carry_flag, zero_flag, neg_flag} !== {p[15:0], c_m, z_m, n_m}) begin
        tests_failed++;
        $display("FAIL mul_%0d: got r=%h czn=%b%b%b exp r=%h czn=%b%b%b", i, result,
                 carry_flag, zero_flag, neg_flag, p[15:0], c_m, z_m, n_m);
      end
      step();
      tests_run++;
      if ({result_valid, ready_out} !== 2'b01) begin
        tests_failed++;
        $display("FAIL mul_after: got v=%b ready=%b exp 0 1", result_valid, ready_out);
      end
    end
  endtask

  task automatic test_flush();
    logic [15:0] prev;
    int seen;
    prev = result;
    do_op(4'd15, 16'd1234, 16'd77, 5'd0);
    step(); step(); step();
    flush = 1'b1; flag_load = 1'b1; flag_in = ~{c_m, z_m, n_m};
    step();
    flush = 1'b0; flag_load = 1'b0;
    tests_run++;
    if ({ready_out, busy, result_valid} !== 3'b100 || {carry_flag, zero_flag, neg_flag} !== {c_m, z_m, n_m}) begin
      tests_failed++;
      $display("FAIL flush_mul: got rdy=%b busy=%b v=%b czn=%b%b%b exp 1 0 0 czn=%b%b%b", ready_out, busy,
               result_valid, carry_flag, zero_flag, neg_flag, c_m, z_m, n_m);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (result_valid) seen++;
      step();
    end
    tests_run++;
    if (seen != 0 || result !== prev) begin
      tests_failed++;
      $display("FAIL flush_no_result: got %0d pulses r=%h exp 0 pulses r=%h", seen, result, prev);
    end
    flush = 1'b1; imm = 16'hABCD;
    do_op(4'd14, 16'h0, 16'h0, 5'd0);
    flush = 1'b0;
    tests_run++;
    if (result_valid !== 1'b0 || result !== prev) begin
      tests_failed++;
      $display("FAIL flush_idle: got v=%b r=%h exp 0 %h", result_valid, result, prev);
    end
  endtask

  task automatic test_rst_mid_mul();
    flag_load = 1'b1; flag_in = 3'b111; imm = 16'h5A5A;
    do_op(4'd14, 16'h0, 16'h0, 5'd0);
    do_op(4'd15, 16'd300, 16'd300, 5'd0);
    step(); step(); step();
    rst = 1'b1;
    step();
    tests_run++;
    if ({result, result_valid, carry_flag, zero_flag, neg_flag, busy} !== 21'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_mul: got r=%h v=%b czn=%b%b%b busy=%b exp all 0", result, result_valid,
               carry_flag, zero_flag, neg_flag, busy);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if ({ready_out, result_valid} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_recover: got rdy=%b v=%b exp 1 0", ready_out, result_valid);
    end
    {c_m, z_m, n_m} = 3'b000;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; op = 4'd0; src_a = '0; src_b = '0; imm = '0; shamt = '0;
    in_port_sel = 1'b0; in_port = '0; flush = 1'b0; flag_load = 1'b0; flag_in = 3'b000;
    test_reset();
    test_directed();
    test_flag_load();
    test_random_single();
    test_mul();
    test_flush();
    test_rst_mid_mul();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_flag_exec.md
Name: alu_flag_exec

Overview:
- Parametrised execute-stage ALU for the pipelined processor.
- Keeps the existing 4-bit op encoding and adds an iterative multi-cycle MUL (op 15), shift carry-out rules and a flush input.
- Adds a registered condition-code register (C/Z/N) that replaces latch-style flag holding, and a flag-restore path for interrupt return.
- Operand forwarding stays outside this block; it receives already-resolved operands.

Parameters:
N, 16, datapath width in bits
SHAMT_W, 5, shift-amount width; must satisfy 2^SHAMT_W > N

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
valid_in  input  1  operation presented this cycle
ready_out  output  1  block can accept an operation this cycle
op  input  4  operation code (see Behaviour)
src_a  input  N  first (source) operand, forwarded value
src_b  input  N  second (destination) operand, forwarded value
imm  input  N  immediate for LDM
shamt  input  SHAMT_W  shift amount
in_port_sel  input  1  with op=0, load in_port
in_port  input  N  external input port value
flush  input  1  kill in-flight MUL and discard the current accept
flag_load  input  1  restore CCR from flag_in
flag_in  input  3  {C,Z,N} restore value
result  output  N  registered result
result_valid  output  1  one-cycle pulse when result is new
carry_flag  output  1  CCR.C
zero_flag  output  1  CCR.Z
neg_flag  output  1  CCR.N
busy  output  1  MUL in progress

Behaviour:
- Reset: result=0, result_valid=0, C=Z=N=0, busy=0, FSM=IDLE, ready_out=1 from the first cycle after reset. While rst=1, no input is accepted.
- Accept condition: valid_in && ready_out && !flush. ready_out = (FSM==IDLE).
- Op codes: 0 NOP (or IN when in_port_sel=1), 1 NOT a, 2 INC a, 3 DEC a, 4 MOV a, 5 ADD a+b, 6 SUB a-b, 7 AND, 8 OR, 9 SHL a by shamt, 10 SHR a by shamt (logical), 11 SETC, 12 CLRC, 13 PASS a (load/store address or data), 14 LDM imm, 15 MUL a*b (unsigned).
- Single-cycle ops, timing:
  - Result and CCR update on the accepting edge.
  - result_valid=1 for exactly the next cycle.
  - Ops 0 without IN, 11 and 12 produce no result_valid.
- Arithmetic is computed at N+1 bits; C is bit N.
  - INC/ADD: C = carry-out.
  - DEC/SUB: C = borrow, i.e. 1 when the unsigned result wraps.
  - NOT: C=0.
- Shifts:
  - shamt=0: result=a, C unchanged.
  - 1<=shamt<=N: SHL C=a[N-shamt]; SHR C=a[shamt-1].
  - shamt>N: result=0, C=0.
- Flag update classes:
  - Z/N update (Z = result==0, N = result[N-1]): ops 1,2,3,5,6,7,8,9,10,15.
  - C update: ops 1,2,3,5,6,9,10,15.
  - AND/OR leave C unchanged.
  - 11 sets C, 12 clears C.
  - Ops 0, 4, 13, 14 and IN leave all flags unchanged.
- MUL FSM, states IDLE, MUL, DONE:
  - IDLE->MUL on accept with op=15: latch a and b, clear a 2N-bit accumulator, count=0, busy=1.
  - MUL: one shift-add step per cycle; after N steps go to DONE.
  - DONE: result = low N bits. Z and N taken from the low half. C=1 if the high half is nonzero (overflow). result_valid pulses. Return to IDLE.
  - Latency: result_valid asserts exactly N+1 cycles after the accepting edge (17 for N=16). ready_out stays low for N+1 cycles.
- Flush:
  - In MUL or DONE: return to IDLE next edge, no result_valid, CCR unchanged, busy=0.
  - In IDLE: nothing is accepted that cycle.
- flag_load:
  - Loads CCR={flag_in} on the edge and overrides any same-edge ALU flag update.
  - A result, if any, is still produced.
- Simultaneous events:
  - rst beats flush, which beats flag_load, which beats ALU flag updates.
  - A new op is accepted in the cycle ready_out returns high, i.e. the cycle after DONE.
- Reset mid-MUL: FSM aborts to IDLE with outputs at reset values.

Test Plan:
- ADD a=16'hFFFF, b=16'h0001 -> result=0, C=1, Z=1, N=0, result_valid one cycle after accept.
- SUB a=3, b=5 -> result=16'hFFFE, C=1, N=1, Z=0; follow with AND 16'h00F0&16'h0F00 -> result=0, Z=1, C stays 1.
- SHL a=16'h8001, shamt=1 -> 16'h0002, C=1. SHR shamt=0 -> result=a, C unchanged. SHL shamt=20 -> 0, C=0.
- MUL a=300, b=300 -> result=16'h5F90 (90000 mod 65536), C=1, valid exactly 17 cycles after accept, ready_out=0 throughout. MUL 7*6 -> 42, C=0.
- Flush at cycle 5 of a MUL -> no result_valid, flags unchanged, ready_out=1 next cycle. Repeat with rst at cycle 5 -> all outputs 0.
- flag_load flag_in=3'b101 on the same edge as ADD 1+1 -> CCR={C=1,Z=0,N=1}, result=2 valid. SETC then CLRC -> C=1 then 0, no result_valid.
